// File: rtl/aurora_frame_gen_chk.sv
// aurora_frame_gen_chk
// Sends and checks numbered AXI4-Stream test frames on the Aurora user
// interface. It is used for loopback bring-up: the generator transmits runs of
// frames and the checker compares received frames against the same pattern.
//
// Ports
//   USER_CLK, RESET_N        : user clock, asynchronous active-low reset
//   channel_up               : Aurora link status; low aborts TX and resyncs RX
//   start, stop              : start is edge-triggered; stop ends a run at the next frame boundary
//   mode, frame_len,
//   num_frames, gap          : run configuration, captured on the start edge
//   tx_tdata/tvalid/tlast,
//   tx_tready                : AXI4-Stream master toward the core
//   rx_tdata/tvalid/tlast    : AXI4-Stream slave from the core (no backpressure)
//   tx_busy, tx_frames,
//   rx_frames_ok,
//   data_err_cnt,
//   len_err_cnt              : run status and saturating counters
//   err_flag, tx_aborted     : sticky status bits
module aurora_frame_gen_chk #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 32,
    parameter int GAP_W  = 8
) (
    input  logic              USER_CLK,
    input  logic              RESET_N,
    input  logic              channel_up,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [CNT_W-1:0]  num_frames,
    input  logic [GAP_W-1:0]  gap,
    output logic [DATA_W-1:0] tx_tdata,
    output logic              tx_tvalid,
    output logic              tx_tlast,
    input  logic              tx_tready,
    input  logic [DATA_W-1:0] rx_tdata,
    input  logic              rx_tvalid,
    input  logic              rx_tlast,
    output logic              tx_busy,
    output logic [CNT_W-1:0]  tx_frames,
    output logic [CNT_W-1:0]  rx_frames_ok,
    output logic [CNT_W-1:0]  data_err_cnt,
    output logic [CNT_W-1:0]  len_err_cnt,
    output logic              err_flag,
    output logic              tx_aborted
);

    localparam int N16 = DATA_W / 16;
    localparam int N32 = DATA_W / 32;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [30:0] prbs_seed(input logic [30:0] s);
        logic [30:0] x;
        x = 31'h7FFF_FFFF ^ s;
        return (x == 31'd0) ? 31'd1 : x;
    endfunction

    // x^31 + x^28 + 1, Fibonacci form: feedback from taps 31 and 28 enters at bit 0
    function automatic logic [30:0] prbs_step(input logic [30:0] x);
        return {x[29:0], x[30] ^ x[27]};
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic m, input logic [7:0] s8,
                                                  input logic [7:0] k8, input logic [30:0] lfsr);
        if (m) return {N32{1'b0, lfsr}};
        return {N16{s8, k8}};
    endfunction

    state_t            state, state_nxt;
    logic              start_d, start_rise, start_go;
    logic              mode_l;
    logic [LEN_W-1:0]  len_l, len_last;
    logic [CNT_W-1:0]  num_l;
    logic [GAP_W-1:0]  gap_l, gap_cnt;

    logic [LEN_W-1:0]  tx_idx;
    logic [30:0]       tx_seq, tx_lfsr, tx_lfsr_cur;
    logic              tx_hs, tx_last_word, frame_done, reach_num;
    logic [CNT_W-1:0]  tx_frames_nxt;

    logic [LEN_W-1:0]  rx_idx;
    logic [30:0]       rx_seq, rx_lfsr, rx_lfsr_cur;
    logic              rx_bad, rx_in_frame, rx_mis, rx_len_e;
    logic [DATA_W-1:0] rx_exp;

    assign start_rise = start & ~start_d;
    assign start_go   = start_rise & channel_up & (state == IDLE);
    assign len_last   = len_l - LEN_W'(1);

    // The LFSR register holds the state for word index > 0; word 0 always uses the seed.
    assign tx_lfsr_cur   = (tx_idx == '0) ? prbs_seed(tx_seq) : tx_lfsr;
    assign tx_last_word  = (tx_idx == len_last);
    assign tx_hs         = tx_tvalid & tx_tready;
    assign frame_done    = tx_hs & tx_last_word & channel_up;
    assign tx_frames_nxt = sat_inc(tx_frames);
    assign reach_num     = (num_l != '0) && (tx_frames_nxt == num_l);

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!channel_up) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start_go) state_nxt = SEND;
                SEND: if (frame_done) begin
                    if (reach_num || stop) state_nxt = DONE;
                    else if (gap_l != '0)  state_nxt = GAP;
                    else                   state_nxt = SEND;
                end
                GAP:  if (gap_cnt == gap_l - GAP_W'(1)) state_nxt = stop ? DONE : SEND;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_tvalid = (state == SEND);
        tx_tlast  = (state == SEND) & tx_last_word;
        tx_busy   = (state == SEND) | (state == GAP);
        tx_tdata  = (state == SEND) ? pattern(mode_l, tx_seq[7:0], tx_idx[7:0], tx_lfsr_cur) : '0;
    end

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            start_d    <= 1'b0;
            mode_l     <= 1'b0;
            len_l      <= LEN_W'(1);
            num_l      <= '0;
            gap_l      <= '0;
            gap_cnt    <= '0;
            tx_idx     <= '0;
            tx_seq     <= '0;
            tx_lfsr    <= '0;
            tx_frames  <= '0;
            tx_aborted <= 1'b0;
        end else begin
            start_d <= start;
            gap_cnt <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (start_go) begin
                mode_l     <= mode;
                len_l      <= (frame_len == '0) ? LEN_W'(1) : frame_len;
                num_l      <= num_frames;
                gap_l      <= gap;
                tx_idx     <= '0;
                tx_seq     <= '0;
                tx_frames  <= '0;
                tx_aborted <= 1'b0;
            end else if (!channel_up) begin
                // Partial frame is discarded; tx_seq is kept so the count stays honest.
                if (state == SEND) tx_aborted <= 1'b1;
                tx_idx <= '0;
            end else if (tx_hs) begin
                if (tx_last_word) begin
                    tx_idx    <= '0;
                    tx_seq    <= tx_seq + 31'd1;
                    tx_frames <= tx_frames_nxt;
                end else begin
                    tx_idx  <= tx_idx + LEN_W'(1);
                    tx_lfsr <= prbs_step(tx_lfsr_cur);
                end
            end
        end
    end

    // rx_idx == len_l marks an overrun frame: words are swallowed until tlast
    // and its single length error has already been counted.
    assign rx_lfsr_cur = (rx_idx == '0) ? prbs_seed(rx_seq) : rx_lfsr;
    assign rx_exp      = pattern(mode_l, rx_seq[7:0], rx_idx[7:0], rx_lfsr_cur);
    assign rx_in_frame = (rx_idx < len_l);
    assign rx_mis      = rx_in_frame & (rx_tdata != rx_exp);
    assign rx_len_e    = rx_tlast ? (rx_idx < len_last) : (rx_idx == len_last);

    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_idx       <= '0;
            rx_seq       <= '0;
            rx_lfsr      <= '0;
            rx_bad       <= 1'b0;
            rx_frames_ok <= '0;
            data_err_cnt <= '0;
            len_err_cnt  <= '0;
        end else if (start_go) begin
            rx_idx       <= '0;
            rx_seq       <= '0;
            rx_bad       <= 1'b0;
            rx_frames_ok <= '0;
            data_err_cnt <= '0;
            len_err_cnt  <= '0;
        end else if (!channel_up) begin
            rx_idx <= '0;
            rx_bad <= 1'b0;
        end else if (rx_tvalid) begin
            if (rx_mis)   data_err_cnt <= sat_inc(data_err_cnt);
            if (rx_len_e) len_err_cnt  <= sat_inc(len_err_cnt);
            if (rx_tlast) begin
                if (!(rx_bad | rx_mis | rx_len_e)) rx_frames_ok <= sat_inc(rx_frames_ok);
                rx_seq <= rx_seq + 31'd1;
                rx_idx <= '0;
                rx_bad <= 1'b0;
            end else begin
                rx_bad <= rx_bad | rx_mis | rx_len_e;
                if (rx_in_frame) begin
                    rx_idx  <= rx_idx + LEN_W'(1);
                    rx_lfsr <= prbs_step(rx_lfsr_cur);
                end
            end
        end
    end

    // Counters only clear on start or reset, so the flag is sticky by construction.
    assign err_flag = (data_err_cnt != '0) | (len_err_cnt != '0);

endmodule

// File: tb/tb_aurora_frame_gen_chk.sv
// Testbench for aurora_frame_gen_chk: TX looped back to RX with optional
// fault injection; table of runs plus hand-written abort and stop sequences.
module tb_aurora_frame_gen_chk;

    logic        USER_CLK = 1'b0;
    logic        RESET_N  = 1'b0;
    logic        channel_up = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        mode  = 1'b0;
    logic [15:0] frame_len = 16'd0;
    logic [31:0] num_frames = 32'd0;
    logic [7:0]  gap = 8'd0;
    logic [63:0] tx_tdata;
    logic        tx_tvalid, tx_tlast;
    logic        tx_tready = 1'b1;
    logic [63:0] rx_tdata;
    logic        rx_tvalid, rx_tlast;
    logic        tx_busy, err_flag, tx_aborted;
    logic [31:0] tx_frames, rx_frames_ok, data_err_cnt, len_err_cnt;

    aurora_frame_gen_chk #(.DATA_W(64), .LEN_W(16), .CNT_W(32), .GAP_W(8)) dut (
        .USER_CLK(USER_CLK), .RESET_N(RESET_N), .channel_up(channel_up),
        .start(start), .stop(stop), .mode(mode), .frame_len(frame_len),
        .num_frames(num_frames), .gap(gap),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
        .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
        .tx_busy(tx_busy), .tx_frames(tx_frames), .rx_frames_ok(rx_frames_ok),
        .data_err_cnt(data_err_cnt), .len_err_cnt(len_err_cnt),
        .err_flag(err_flag), .tx_aborted(tx_aborted)
    );

    always #5 USER_CLK = ~USER_CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state: index of the TX word currently presented
    int mon_frame = 0, mon_word = 0;
    int cyc = 0, tr_mode = 0, idle = 0;
    bit in_gap = 0, prev_stall = 0, hs = 0, tl = 0;
    logic [63:0] stall_data = '0;
    bit c_mode = 0;
    int c_len = 1, c_gap = 0;

    // Injection: 1 = flip bit 0 of word inj_w in frame inj_f,
    //            2 = early tlast at word inj_w and drop the rest of that frame
    int inj_kind = 0, inj_f = 0, inj_w = 0;
    wire inj_hit = (mon_frame == inj_f) && (mon_word == inj_w);

    assign rx_tdata  = tx_tdata ^ {63'd0, (inj_kind == 1) && inj_hit};
    assign rx_tlast  = tx_tlast | ((inj_kind == 2) && inj_hit);
    assign rx_tvalid = tx_tvalid & tx_tready &
                       !((inj_kind == 2) && (mon_frame == inj_f) && (mon_word > inj_w));

    typedef struct {
        bit mode; int len; int num; int gap; int trm;
        int inj_kind; int inj_f; int inj_w;
        int e_tx; int e_ok; int e_de; int e_le; bit e_ef;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_word(input bit m, input int s, input int k);
        logic [30:0] r;
        logic [7:0]  sb, kb;
        if (!m) begin
            sb = s[7:0];
            kb = k[7:0];
            return {4{sb, kb}};
        end
        r = 31'h7FFF_FFFF ^ s[30:0];
        if (r == 31'd0) r = 31'd1;
        for (int i = 0; i < k; i++) r = {r[29:0], r[30] ^ r[27]};
        return {2{1'b0, r}};
    endfunction

    // One clock: check TX at the falling edge, advance the word index after the rising edge.
    task automatic step();
        @(negedge USER_CLK);
        if (prev_stall && tx_tvalid) check("stall_hold", tx_tdata, stall_data);
        if (tx_tvalid) begin
            check($sformatf("tx_data f%0d w%0d", mon_frame, mon_word), tx_tdata,
                  exp_word(c_mode, mon_frame, mon_word));
            check($sformatf("tx_tlast f%0d w%0d", mon_frame, mon_word), 64'(tx_tlast),
                  64'(mon_word == c_len - 1));
            if (in_gap) begin
                check("gap_len", 64'(idle), 64'(c_gap));
                in_gap = 0;
            end
        end else if (in_gap) begin
            idle++;
        end
        hs = tx_tvalid & tx_tready;
        tl = tx_tlast;
        prev_stall = tx_tvalid & !tx_tready;
        stall_data = tx_tdata;
        if (hs && tl) begin
            in_gap = 1;
            idle = 0;
        end
        @(posedge USER_CLK);
        #1;
        if (hs) begin
            if (tl) begin
                mon_frame++;
                mon_word = 0;
            end else begin
                mon_word++;
            end
        end
        cyc++;
        tx_tready = (tr_mode == 0) ? 1'b1 : cyc[0];
    endtask

    task automatic start_run(input bit m, input int len, input int num, input int g, input int trm);
        mode = m; frame_len = 16'(len); num_frames = 32'(num); gap = 8'(g);
        c_mode = m; c_len = (len == 0) ? 1 : len; c_gap = g; tr_mode = trm;
        mon_frame = 0; mon_word = 0; in_gap = 0; prev_stall = 0; cyc = 0;
        tx_tready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("first_tvalid_latency", 64'(tx_tvalid), 64'd1);
        if (m) check("prbs_frame0_word0", tx_tdata, 64'h7FFF_FFFF_7FFF_FFFF);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (tx_busy && n < 3000) begin
            step();
            n++;
        end
        check("run_completes", 64'(tx_busy), 64'd0);
    endtask

    initial begin
        //             mode len num gap trm kind f w  tx ok de le ef
        tbl[0] = '{0,   4,  3,  2,  0,  0,  0, 0, 3, 3, 0, 0, 0};
        tbl[1] = '{1,   8,  5,  1,  1,  0,  0, 0, 5, 5, 0, 0, 0};
        tbl[2] = '{0,   4,  3,  1,  0,  1,  1, 2, 3, 2, 1, 0, 1};
        tbl[3] = '{0,   4,  3,  1,  0,  2,  0, 2, 3, 2, 0, 1, 1};
        tbl[4] = '{1,   0,  2,  0,  0,  0,  0, 0, 2, 2, 0, 0, 0};
        tbl[5] = '{1,   5,  2,  3,  1,  1,  0, 4, 2, 1, 1, 0, 1};

        repeat (3) @(posedge USER_CLK);
        @(negedge USER_CLK);
        check("reset tx_tvalid", 64'(tx_tvalid), 64'd0);
        check("reset tx_tdata", tx_tdata, 64'd0);
        check("reset tx_busy", 64'(tx_busy), 64'd0);
        check("reset counters", {tx_frames, rx_frames_ok | data_err_cnt | len_err_cnt}, 64'd0);
        check("reset flags", {62'd0, err_flag, tx_aborted}, 64'd0);
        @(posedge USER_CLK);
        #1;
        RESET_N = 1'b1;
        channel_up = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            inj_kind = tbl[i].inj_kind; inj_f = tbl[i].inj_f; inj_w = tbl[i].inj_w;
            start_run(tbl[i].mode, tbl[i].len, tbl[i].num, tbl[i].gap, tbl[i].trm);
            wait_idle();
            step();
            step();
            check($sformatf("case%0d tx_frames", i), 64'(tx_frames), 64'(tbl[i].e_tx));
            check($sformatf("case%0d rx_frames_ok", i), 64'(rx_frames_ok), 64'(tbl[i].e_ok));
            check($sformatf("case%0d data_err_cnt", i), 64'(data_err_cnt), 64'(tbl[i].e_de));
            check($sformatf("case%0d len_err_cnt", i), 64'(len_err_cnt), 64'(tbl[i].e_le));
            check($sformatf("case%0d err_flag", i), 64'(err_flag), 64'(tbl[i].e_ef));
            check($sformatf("case%0d tx_words", i), 64'(mon_frame), 64'(tbl[i].e_tx));
            inj_kind = 0;
        end

        // channel_up lost in the middle of frame 2 of a continuous run
        start_run(0, 4, 0, 1, 0);
        for (int n = 0; n < 200 && !(mon_frame == 2 && mon_word == 1); n++) step();
        check("drop reached frame 2", 64'(mon_frame), 64'd2);
        channel_up = 1'b0;
        step();
        check("drop tx_tvalid", 64'(tx_tvalid), 64'd0);
        check("drop tx_aborted", 64'(tx_aborted), 64'd1);
        check("drop tx_frames", 64'(tx_frames), 64'd2);
        check("drop tx_busy", 64'(tx_busy), 64'd0);
        check("drop rx_frames_ok", 64'(rx_frames_ok), 64'd2);
        channel_up = 1'b1;
        step();
        step();
        start_run(0, 4, 1, 0, 0);
        check("restart clears tx_aborted", 64'(tx_aborted), 64'd0);
        check("restart clears tx_frames", 64'(tx_frames), 64'd0);
        check("restart clears rx_frames_ok", 64'(rx_frames_ok), 64'd0);
        wait_idle();
        step();
        check("restart tx_frames", 64'(tx_frames), 64'd1);
        check("restart rx_frames_ok", 64'(rx_frames_ok), 64'd1);

        // Continuous run ended by stop mid-frame; a start edge while busy is ignored
        start_run(0, 4, 0, 0, 0);
        for (int n = 0; n < 200 && mon_frame < 1; n++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b1;
        wait_idle();
        stop = 1'b0;
        step();
        check("stop tx_frames", 64'(tx_frames), 64'd2);
        check("stop frame completed", {32'(mon_frame), 32'(mon_word)}, {32'd2, 32'd0});
        check("stop rx_frames_ok", 64'(rx_frames_ok), 64'd2);
        check("stop tx_busy", 64'(tx_busy), 64'd0);
        check("stop err_flag", 64'(err_flag), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aurora_frame_gen_chk.md
Name: aurora_frame_gen_chk

Overview:
- Parametrised AXI4-Stream frame generator plus checker for the Aurora user interface.
- Sits between the Aurora core user ports and the control/status logic on the core's user clock.
- Transmits numbered frames of a configurable length and pattern, and checks received frames against the same pattern.
- Intended use is loopback bring-up: near-end PMA, near-end PCS, or external loopback.
- Counts good frames, data-word errors and length errors.

Parameters:
- DATA_W, 64, TX/RX data width in bits; multiple of 32, minimum 32.
- LEN_W, 16, width of frame_len, in words.
- CNT_W, 32, width of the frame and error counters; all counters saturate.
- GAP_W, 8, width of the inter-frame gap setting.

Ports:
- USER_CLK, in, 1, Aurora user clock; the only clock.
- RESET_N, in, 1, asynchronous active-low reset.
- channel_up, in, 1, Aurora channel_up, synchronous to USER_CLK.
- start, in, 1, rising edge starts a run.
- stop, in, 1, level; ends a run at the next frame boundary.
- mode, in, 1, pattern select: 0 = counter, 1 = PRBS-31.
- frame_len, in, LEN_W, words per frame; 0 is treated as 1.
- num_frames, in, CNT_W, frames per run; 0 = continuous until stop.
- gap, in, GAP_W, idle cycles between frames.
- tx_tdata, out, DATA_W, TX data.
- tx_tvalid, out, 1, TX valid.
- tx_tlast, out, 1, TX last word of frame.
- tx_tready, in, 1, TX ready.
- rx_tdata, in, DATA_W, RX data.
- rx_tvalid, in, 1, RX valid; there is no RX backpressure.
- rx_tlast, in, 1, RX last word of frame.
- tx_busy, out, 1, run in progress.
- tx_frames, out, CNT_W, frames fully sent.
- rx_frames_ok, out, CNT_W, frames received with no error.
- data_err_cnt, out, CNT_W, mismatched RX words.
- len_err_cnt, out, CNT_W, frames with a length error.
- err_flag, out, 1, sticky; set by any error.
- tx_aborted, out, 1, sticky; set when channel_up drops while SEND.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; tx_seq = 0; rx_seq = 0.
- mode, frame_len, num_frames and gap are latched on the start edge. The checker uses the latched copies.
- Pattern for word k (0-based) of frame with sequence number s:
  - Counter mode: DATA_W/16 copies of {s[7:0], k[7:0]}.
  - PRBS mode: 31-bit LFSR, polynomial x^31+x^28+1, Fibonacci form, shifted once per word. It is seeded at word 0 with 31'h7FFFFFFF ^ {s[30:0]}; a seed of 0 is forced to 1. The word is DATA_W/32 copies of {1'b0, lfsr}, and word 0 uses the seed value itself.
- Generator FSM:
  - IDLE -> SEND on a start rising edge while channel_up = 1. A start edge seen while busy is ignored.
  - SEND: tx_tvalid = 1. Word index advances only when tx_tvalid & tx_tready; tdata, tvalid and tlast are held stable while tready = 0. tx_tlast = 1 on word frame_len-1.
  - Completion of the last word increments tx_frames and tx_seq. The FSM then moves to GAP if gap > 0, otherwise back-to-back SEND, or to DONE.
  - GAP: counts gap cycles with tvalid = 0, then returns to SEND or goes to DONE.
  - DONE is entered when the sent count equals num_frames (num_frames != 0), or when stop = 1 at a frame boundary. DONE -> IDLE next cycle.
  - tx_busy = 1 in SEND and GAP.
  - channel_up = 0 in any state forces IDLE next cycle with tx_tvalid = 0. If this happens in SEND, tx_aborted is set; the partial frame is not counted and tx_seq is unchanged.
- Checker (active whenever channel_up = 1):
  - Each rx_tvalid word is compared with the expected pattern for (rx_seq, rx index).
  - A mismatch increments data_err_cnt by 1 per word and marks the frame bad.
  - rx_tlast at index != frame_len-1 is a length error. So is reaching index frame_len-1 without tlast; in that case the checker keeps consuming words up to tlast and counts one len_err per frame.
  - On tlast: rx_frames_ok increments if the frame is good, rx_seq increments, and the index clears.
  - channel_up = 0 clears the rx index and the bad flag; rx_seq is kept.
  - A start edge clears all counters, both sequence numbers and both sticky flags.
- err_flag = 1 when data_err_cnt or len_err_cnt is non-zero; cleared only by start or reset.
- Counters saturate at all-ones.
- Latency: the first tx_tvalid is asserted 1 cycle after the start edge is sampled. Checker counters update 1 cycle after the RX tlast word.

Test Plan:
- Loopback TX->RX with zero delay; mode 0, frame_len 4, num_frames 3, gap 2, tready = 1. Required: 12 valid words; tlast on words 3, 7, 11; 2 idle cycles between frames; tx_frames = 3; rx_frames_ok = 3; err_flag = 0; tx_busy drops after the last word.
- PRBS mode, DATA_W = 64, frame_len 8, with tready toggling 1010... Required: data held stable while stalled; frame s = 0 word 0 = 64'h7FFFFFFF_7FFFFFFF; no errors after 5 frames.
- Bit 0 of RX word 2 in frame 1 flipped. Required: data_err_cnt = 1; rx_frames_ok = num_frames - 1; err_flag = 1.
- RX tlast injected on word 2 with frame_len 4. Required: len_err_cnt = 1; the next frame is checked with rx_seq advanced.
- channel_up dropped in the middle of frame 2 of a continuous run. Required: tx_tvalid = 0 next cycle; tx_aborted = 1; tx_frames = 2; a new start edge clears all counters and flags.
- Continuous run (num_frames 0) with stop asserted in the middle of a frame. Required: the current frame completes with tlast, then DONE, and tx_busy = 0.
